// File: rtl/param_stack_unit.sv
// Parametrised LIFO operand stack with registered TOS/NOS, in-place ops and sticky error flags.
module param_stack_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [DATA_W-1:0] push_data,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] nos,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              err_ovf,
  output logic              err_unf,
  input  logic              err_clr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_REPL  = 3'b011;
  localparam logic [2:0] OP_DUP   = 3'b100;
  localparam logic [2:0] OP_SWAP  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWAP2 = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic [DATA_W-1:0] nos_q, nos_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              empty_q, full_q, ready_q;

  logic              we_a, we_b;
  logic [IDX_W-1:0]  addr_a, addr_b;
  logic [DATA_W-1:0] wd_a, wd_b;
  logic [CNT_W-1:0]  cnt_m1, cnt_m2, cnt_m3;
  logic              accept;

  assign cnt_m1 = count_q - CNT_W'(1);
  assign cnt_m2 = count_q - CNT_W'(2);
  assign cnt_m3 = count_q - CNT_W'(3);
  assign accept = cmd_valid & (state_q == S_IDLE);

  // Next-state, storage write ports and error flag update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    ovf_d   = err_clr ? 1'b0 : ovf_q;
    unf_d   = err_clr ? 1'b0 : unf_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    addr_a  = IDX_W'(count_q);
    addr_b  = IDX_W'(cnt_m2);
    wd_a    = push_data;
    wd_b    = tos_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            OP_PUSH: begin
              if (full_q) begin
                ovf_d = 1'b1;
              end else begin
                we_a    = 1'b1;
                addr_a  = IDX_W'(count_q);
                wd_a    = push_data;
                count_d = count_q + CNT_W'(1);
                tos_d   = push_data;
                nos_d   = tos_q;
              end
            end
            OP_POP: begin
              if (empty_q) begin
                unf_d = 1'b1;
              end else begin
                count_d = cnt_m1;
                tos_d   = nos_q;
                nos_d   = (cnt_m1 >= CNT_W'(2)) ? mem[IDX_W'(cnt_m3)] : '0;
              end
            end
            OP_REPL: begin
              if (empty_q) begin
                unf_d = 1'b1;
              end else begin
                we_a   = 1'b1;
                addr_a = IDX_W'(cnt_m1);
                wd_a   = push_data;
                tos_d  = push_data;
              end
            end
            OP_DUP: begin
              if (full_q) begin
                ovf_d = 1'b1;
              end else if (empty_q) begin
                unf_d = 1'b1;
              end else begin
                we_a    = 1'b1;
                addr_a  = IDX_W'(count_q);
                wd_a    = tos_q;
                count_d = count_q + CNT_W'(1);
                nos_d   = tos_q;
              end
            end
            OP_SWAP: begin
              if (count_q < CNT_W'(2)) begin
                unf_d = 1'b1;
              end else begin
                state_d = S_SWAP2;
              end
            end
            OP_CLEAR: begin
              count_d = '0;
              tos_d   = '0;
              nos_d   = '0;
            end
            default: ;
          endcase
        end
      end
      S_SWAP2: begin
        we_a    = 1'b1;
        addr_a  = IDX_W'(cnt_m1);
        wd_a    = nos_q;
        we_b    = 1'b1;
        addr_b  = IDX_W'(cnt_m2);
        wd_b    = tos_q;
        tos_d   = nos_q;
        nos_d   = tos_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
      ready_q <= (state_d == S_IDLE);
    end
  end

  // Stack storage; not reset, only entries below count are ever observed
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wd_a;
    if (we_b) mem[addr_b] <= wd_b;
  end

  assign cmd_ready = ready_q;
  assign tos       = tos_q;
  assign nos       = nos_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: tb/tb_param_stack_unit.sv
// Directed bench for param_stack_unit (DEPTH=4 so full/overflow is reachable quickly).
module tb_param_stack_unit;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REPL = 3'b011;
  localparam logic [2:0] DUP = 3'b100, SWAP = 3'b101, CLEAR = 3'b110, RSVD = 3'b111;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic              cmd_ready;
  logic [DATA_W-1:0] tos, nos;
  logic [CNT_W-1:0]  count;
  logic              empty, full, err_ovf, err_unf;

  int tests = 0;
  int fails = 0;

  param_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .push_data(push_data),
    .cmd_ready(cmd_ready), .tos(tos), .nos(nos), .count(count), .empty(empty),
    .full(full), .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // One accepted-cycle command; outputs sampled 1 time unit after the edge
  task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic clr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = op; push_data = d; err_clr = clr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd = NOP; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd = NOP; push_data = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (count !== 3'd0 || tos !== 8'h00 || nos !== 8'h00) begin fails++; $display("FAIL reset_data count=%0d tos=%h nos=%h want 0/00/00", count, tos, nos); end
    tests++; if (empty !== 1'b1 || full !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_status empty=%b full=%b ready=%b want 1/0/1", empty, full, cmd_ready); end
    tests++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin fails++; $display("FAIL reset_flags ovf=%b unf=%b want 0/0", err_ovf, err_unf); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_push();
    issue(PUSH, 8'h11, 1'b0);
    issue(PUSH, 8'h22, 1'b0);
    issue(PUSH, 8'h33, 1'b0);
    tests++; if (count !== 3'd3 || tos !== 8'h33 || nos !== 8'h22) begin fails++; $display("FAIL push3 count=%0d tos=%h nos=%h want 3/33/22", count, tos, nos); end
    tests++; if (empty !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin fails++; $display("FAIL push3_status empty=%b ovf=%b unf=%b want 0/0/0", empty, err_ovf, err_unf); end
  endtask

  task automatic test_pop();
    issue(POP, 8'h00, 1'b0);
    tests++; if (count !== 3'd2 || tos !== 8'h22 || nos !== 8'h11) begin fails++; $display("FAIL pop1 count=%0d tos=%h nos=%h want 2/22/11", count, tos, nos); end
    issue(POP, 8'h00, 1'b0);
    tests++; if (count !== 3'd1 || tos !== 8'h11 || nos !== 8'h00) begin fails++; $display("FAIL pop2 count=%0d tos=%h nos=%h want 1/11/00", count, tos, nos); end
    issue(POP, 8'h00, 1'b0);
    tests++; if (count !== 3'd0 || tos !== 8'h00 || empty !== 1'b1) begin fails++; $display("FAIL pop3 count=%0d tos=%h empty=%b want 0/00/1", count, tos, empty); end
    issue(POP, 8'h00, 1'b0);
    tests++; if (err_unf !== 1'b1 || count !== 3'd0 || err_ovf !== 1'b0) begin fails++; $display("FAIL pop_underflow unf=%b count=%0d ovf=%b want 1/0/0", err_unf, count, err_ovf); end
    issue(NOP, 8'h00, 1'b1);
    tests++; if (err_unf !== 1'b0) begin fails++; $display("FAIL unf_clear unf=%b want 0", err_unf); end
  endtask

  task automatic test_overflow();
    issue(PUSH, 8'h01, 1'b0);
    issue(PUSH, 8'h02, 1'b0);
    issue(PUSH, 8'h03, 1'b0);
    issue(PUSH, 8'h04, 1'b0);
    tests++; if (full !== 1'b1 || count !== 3'd4 || nos !== 8'h03) begin fails++; $display("FAIL fill full=%b count=%0d nos=%h want 1/4/03", full, count, nos); end
    issue(PUSH, 8'h05, 1'b0);
    tests++; if (err_ovf !== 1'b1 || tos !== 8'h04 || count !== 3'd4) begin fails++; $display("FAIL overflow ovf=%b tos=%h count=%0d want 1/04/4", err_ovf, tos, count); end
    issue(NOP, 8'h00, 1'b1);
    tests++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin fails++; $display("FAIL ovf_clear ovf=%b unf=%b want 0/0", err_ovf, err_unf); end
    issue(PUSH, 8'h06, 1'b1);
    tests++; if (err_ovf !== 1'b1 || tos !== 8'h04) begin fails++; $display("FAIL set_wins ovf=%b tos=%h want 1/04", err_ovf, tos); end
    issue(POP, 8'h00, 1'b1);
    tests++; if (count !== 3'd3 || tos !== 8'h03 || nos !== 8'h02 || full !== 1'b0 || err_ovf !== 1'b0) begin fails++; $display("FAIL pop_from_full count=%0d tos=%h nos=%h full=%b ovf=%b want 3/03/02/0/0", count, tos, nos, full, err_ovf); end
    issue(POP, 8'h00, 1'b0);
    tests++; if (tos !== 8'h02 || nos !== 8'h01) begin fails++; $display("FAIL pop_mem tos=%h nos=%h want 02/01", tos, nos); end
    issue(CLEAR, 8'h00, 1'b0);
  endtask

  task automatic test_swap();
    issue(PUSH, 8'h0A, 1'b0);
    issue(PUSH, 8'h0B, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = SWAP;
    @(posedge clk); #1;
    tests++; if (cmd_ready !== 1'b0 || tos !== 8'h0B) begin fails++; $display("FAIL swap_busy ready=%b tos=%h want 0/0b", cmd_ready, tos); end
    cmd = PUSH; push_data = 8'h0C;
    @(posedge clk); #1;
    tests++; if (tos !== 8'h0A || nos !== 8'h0B || count !== 3'd2 || cmd_ready !== 1'b1) begin fails++; $display("FAIL swap_done tos=%h nos=%h count=%0d ready=%b want 0a/0b/2/1", tos, nos, count, cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = NOP;
    tests++; if (tos !== 8'h0C || nos !== 8'h0A || count !== 3'd3) begin fails++; $display("FAIL held_push tos=%h nos=%h count=%0d want 0c/0a/3", tos, nos, count); end
    issue(POP, 8'h00, 1'b0);
    tests++; if (tos !== 8'h0A || nos !== 8'h0B) begin fails++; $display("FAIL swap_mem tos=%h nos=%h want 0a/0b", tos, nos); end
    issue(POP, 8'h00, 1'b0);
    tests++; if (tos !== 8'h0B || nos !== 8'h00 || count !== 3'd1) begin fails++; $display("FAIL swap_mem2 tos=%h nos=%h count=%0d want 0b/00/1", tos, nos, count); end
    issue(CLEAR, 8'h00, 1'b0);
  endtask

  task automatic test_repl_dup();
    issue(REPL, 8'h77, 1'b0);
    tests++; if (err_unf !== 1'b1 || count !== 3'd0 || tos !== 8'h00) begin fails++; $display("FAIL repl_empty unf=%b count=%0d tos=%h want 1/0/00", err_unf, count, tos); end
    issue(PUSH, 8'h05, 1'b0);
    issue(REPL, 8'h09, 1'b0);
    tests++; if (tos !== 8'h09 || nos !== 8'h00 || count !== 3'd1) begin fails++; $display("FAIL repl tos=%h nos=%h count=%0d want 09/00/1", tos, nos, count); end
    issue(DUP, 8'h00, 1'b0);
    tests++; if (count !== 3'd2 || tos !== 8'h09 || nos !== 8'h09) begin fails++; $display("FAIL dup count=%0d tos=%h nos=%h want 2/09/09", count, tos, nos); end
    issue(PUSH, 8'h0E, 1'b0);
    issue(POP, 8'h00, 1'b0);
    issue(POP, 8'h00, 1'b0);
    tests++; if (tos !== 8'h09 || count !== 3'd1) begin fails++; $display("FAIL repl_mem tos=%h count=%0d want 09/1", tos, count); end
    issue(CLEAR, 8'h00, 1'b0);
    tests++; if (count !== 3'd0 || tos !== 8'h00 || nos !== 8'h00 || err_unf !== 1'b1) begin fails++; $display("FAIL clear count=%0d tos=%h nos=%h unf=%b want 0/00/00/1", count, tos, nos, err_unf); end
    issue(NOP, 8'h00, 1'b1);
    issue(DUP, 8'h00, 1'b0);
    tests++; if (err_unf !== 1'b1 || count !== 3'd0) begin fails++; $display("FAIL dup_empty unf=%b count=%0d want 1/0", err_unf, count); end
    issue(NOP, 8'h00, 1'b1);
  endtask

  task automatic test_nop();
    issue(PUSH, 8'h03, 1'b0);
    issue(NOP, 8'hFF, 1'b0);
    issue(RSVD, 8'hFF, 1'b0);
    tests++; if (tos !== 8'h03 || count !== 3'd1 || err_unf !== 1'b0 || err_ovf !== 1'b0) begin fails++; $display("FAIL nop tos=%h count=%0d unf=%b ovf=%b want 03/1/0/0", tos, count, err_unf, err_ovf); end
  endtask

  task automatic test_swap_err_and_reset();
    issue(SWAP, 8'h00, 1'b0);
    tests++; if (err_unf !== 1'b1 || cmd_ready !== 1'b1 || tos !== 8'h03) begin fails++; $display("FAIL swap_short unf=%b ready=%b tos=%h want 1/1/03", err_unf, cmd_ready, tos); end
    issue(PUSH, 8'h08, 1'b1);
    issue(SWAP, 8'h00, 1'b0);
    tests++; if (cmd_ready !== 1'b0 || count !== 3'd2) begin fails++; $display("FAIL swap_busy2 ready=%b count=%0d want 0/2", cmd_ready, count); end
    #1 rst = 1'b0;
    #1;
    tests++; if (count !== 3'd0 || cmd_ready !== 1'b1 || tos !== 8'h00 || nos !== 8'h00 || err_unf !== 1'b0) begin fails++; $display("FAIL reset_mid_swap count=%0d ready=%b tos=%h nos=%h unf=%b want 0/1/00/00/0", count, cmd_ready, tos, nos, err_unf); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (cmd_ready !== 1'b1 || tos !== 8'h00) begin fails++; $display("FAIL after_reset ready=%b tos=%h want 1/00", cmd_ready, tos); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_overflow();
    test_swap();
    test_repl_dup();
    test_nop();
    test_swap_err_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
